gate_sequencer: RTL

Sequencer that sits directly downstream of the netlist reader. It starts the reader, latches the netlist header sizes, then walks the gate index from 0 to gate_size-1. Each decoded gate is issued as a registered request to the garbling core over a valid/ready handshake. It also counts XOR and non-XOR gates and checks the XOR total against the header.

---
 rtl/gate_sequencer.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/gate_sequencer.sv
// Walks the netlist reader gate by gate and issues each gate as a registered valid/ready request to the garbler.
// Latency: one cycle from nl_gid to the g_* request; up to one gate per cycle while g_ready is held high.
// Backpressure: when g_ready is low the request register holds its fields and gid stalls, so no gate is dropped or repeated.
module gate_sequencer #(
    parameter int S = 20
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    output logic         nl_start,
    input  logic         nl_done,
    output logic [S-1:0] nl_gid,
    input  logic [S-1:0] nl_input_size,
    input  logic [S-1:0] nl_dff_size,
    input  logic [S-1:0] nl_gate_size,
    input  logic [S-1:0] nl_num_XOR,
    input  logic [S-1:0] nl_in0,
    input  logic [S-1:0] nl_in1,
    input  logic         nl_in0F,
    input  logic         nl_in1F,
    input  logic [3:0]   nl_g_logic,
    input  logic         nl_is_output,
    output logic         g_valid,
    input  logic         g_ready,
    output logic [S-1:0] g_id,
    output logic [S-1:0] g_in0,
    output logic [S-1:0] g_in1,
    output logic         g_in0F,
    output logic         g_in1F,
    output logic         g_is_output,
    output logic [3:0]   g_logic,
    output logic         g_is_xor,
    output logic         g_one_in,
    output logic [S-1:0] g_out_wire,
    output logic         busy,
    output logic         done,
    output logic [S-1:0] xor_cnt,
    output logic [S-1:0] nxor_cnt,
    output logic         err
);

    typedef enum logic [2:0] {IDLE, HDR, RUN, DRAIN, FIN} state_t;

    typedef struct packed {
        logic [S-1:0] id;
        logic [S-1:0] in0;
        logic [S-1:0] in1;
        logic [S-1:0] out_wire;
        logic         in0f;
        logic         in1f;
        logic         is_output;
        logic [3:0]   tt;
        logic         is_xor;
        logic         one_in;
    } req_t;

    state_t       state_q, state_d;
    logic         nl_start_q, nl_start_d;
    logic [S-1:0] gid_q, gid_d;
    logic [S-1:0] input_size_q, input_size_d;
    logic [S-1:0] dff_size_q, dff_size_d;
    logic [S-1:0] gate_size_q, gate_size_d;
    logic [S-1:0] num_xor_q, num_xor_d;
    logic         g_valid_q, g_valid_d;
    req_t         req_q, req_d;
    logic [S-1:0] xor_cnt_q, xor_cnt_d;
    logic [S-1:0] nxor_cnt_q, nxor_cnt_d;
    logic         err_q, err_d;
    logic         hs, load, xor_mismatch;

    assign hs           = g_valid_q & g_ready;
    assign load         = (state_q == RUN) & (~g_valid_q | g_ready);
    assign xor_mismatch = (xor_cnt_q != num_xor_q);

    always_comb begin
        state_d      = state_q;
        nl_start_d   = 1'b0;
        gid_d        = gid_q;
        input_size_d = input_size_q;
        dff_size_d   = dff_size_q;
        gate_size_d  = gate_size_q;
        num_xor_d    = num_xor_q;
        g_valid_d    = g_valid_q;
        req_d        = req_q;
        xor_cnt_d    = xor_cnt_q;
        nxor_cnt_d   = nxor_cnt_q;
        err_d        = err_q;

        if (hs) begin
            if (req_q.is_xor) xor_cnt_d  = xor_cnt_q + S'(1);
            else              nxor_cnt_d = nxor_cnt_q + S'(1);
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = HDR;
                    nl_start_d = 1'b1;
                    xor_cnt_d  = '0;
                    nxor_cnt_d = '0;
                    err_d      = 1'b0;
                end
            end
            HDR: begin
                if (nl_done) begin
                    input_size_d = nl_input_size;
                    dff_size_d   = nl_dff_size;
                    gate_size_d  = nl_gate_size;
                    num_xor_d    = nl_num_XOR;
                    gid_d        = '0;
                    state_d      = (nl_gate_size == '0) ? FIN : RUN;
                end
            end
            RUN: begin
                // A stalled request keeps g_valid high; only a fresh load replaces it.
                if (load) begin
                    g_valid_d      = 1'b1;
                    req_d.id       = gid_q;
                    req_d.in0      = nl_in0;
                    req_d.in1      = nl_in1;
                    req_d.out_wire = input_size_q + dff_size_q + gid_q;
                    req_d.in0f     = nl_in0F;
                    req_d.in1f     = nl_in1F;
                    req_d.is_output = nl_is_output;
                    req_d.tt       = nl_g_logic;
                    req_d.is_xor   = (nl_g_logic == 4'b0110);
                    req_d.one_in   = &nl_in1;
                    gid_d          = gid_q + S'(1);
                    if (gid_q == gate_size_q - S'(1)) state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (hs) begin
                    g_valid_d = 1'b0;
                    state_d   = FIN;
                end
            end
            FIN: begin
                err_d   = xor_mismatch;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            nl_start_q   <= 1'b0;
            gid_q        <= '0;
            input_size_q <= '0;
            dff_size_q   <= '0;
            gate_size_q  <= '0;
            num_xor_q    <= '0;
            g_valid_q    <= 1'b0;
            req_q        <= '0;
            xor_cnt_q    <= '0;
            nxor_cnt_q   <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            nl_start_q   <= nl_start_d;
            gid_q        <= gid_d;
            input_size_q <= input_size_d;
            dff_size_q   <= dff_size_d;
            gate_size_q  <= gate_size_d;
            num_xor_q    <= num_xor_d;
            g_valid_q    <= g_valid_d;
            req_q        <= req_d;
            xor_cnt_q    <= xor_cnt_d;
            nxor_cnt_q   <= nxor_cnt_d;
            err_q        <= err_d;
        end
    end

    assign nl_start    = nl_start_q;
    assign nl_gid      = (state_q == RUN) ? gid_q : '0;
    assign g_valid     = g_valid_q;
    assign g_id        = req_q.id;
    assign g_in0       = req_q.in0;
    assign g_in1       = req_q.in1;
    assign g_in0F      = req_q.in0f;
    assign g_in1F      = req_q.in1f;
    assign g_is_output = req_q.is_output;
    assign g_logic     = req_q.tt;
    assign g_is_xor    = req_q.is_xor;
    assign g_one_in    = req_q.one_in;
    assign g_out_wire  = req_q.out_wire;
    assign busy        = (state_q != IDLE);
    assign done        = (state_q == FIN);
    assign xor_cnt     = xor_cnt_q;
    assign nxor_cnt    = nxor_cnt_q;
    // err is already valid in the done cycle; the flop keeps it afterwards.
    assign err         = (state_q == FIN) ? xor_mismatch : err_q;

endmodule
